// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
// panel_pkg : shared chain geometry and sequencer state encoding
// Rev 1.0   : initial release
// ============================================================================
package panel_pkg;

  localparam int CHAIN_BITS = 16;
  localparam int OUT_CHAINS = 4;
  localparam int IN_CHAINS  = 5;

  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    SNAP   = 3'd1,
    SHOUT  = 3'd2,
    LATCH  = 3'd3,
    LOAD   = 3'd4,
    SHIN   = 3'd5,
    COMMIT = 3'd6
  } state_e;

  // Each serial-clock period is split into an A (falling) and B (rising) half.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/serial_tick_gen.sv
`default_nettype none
// ============================================================================
// serial_tick_gen : one-cycle tick every CLK_DIV clocks, restartable by clear
// Rev 1.0         : initial release
// ============================================================================
module serial_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clear_i && (cnt_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/serial_panel_sequencer.sv
`default_nettype none
// ============================================================================
// serial_panel_sequencer : framed 74LV595 lamp / 74LV165 switch chain driver
// Rev 1.0                : initial release
// ============================================================================
module serial_panel_sequencer
  import panel_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CHAIN_BITS = panel_pkg::CHAIN_BITS,
  parameter int OUT_CHAINS = panel_pkg::OUT_CHAINS,
  parameter int IN_CHAINS  = panel_pkg::IN_CHAINS,
  parameter int REFRESH    = 50000
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [OUT_CHAINS*CHAIN_BITS-1:0] out_data,
  input  logic                             frame_req,
  output logic [IN_CHAINS*CHAIN_BITS-1:0]  in_data,
  output logic                             in_update,
  output logic                             busy,
  output logic                             SRCLK,
  output logic                             RCLK,
  output logic                             SH_LDn,
  output logic [OUT_CHAINS-1:0]            SER,
  input  logic [IN_CHAINS-1:0]             QH
);

  localparam int            BW       = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;
  localparam int            RW       = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [BW-1:0] BIT_MSB  = BW'(CHAIN_BITS - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);

  state_e                                 state_q, state_d;
  phase_e                                 ph_q, ph_d;
  logic [BW-1:0]                          bit_q, bit_d;
  logic [RW-1:0]                          ref_q, ref_d;
  logic                                   pend_q, pend_d;
  logic [OUT_CHAINS-1:0][CHAIN_BITS-1:0]  shadow_q, shadow_d;
  logic [IN_CHAINS-1:0][CHAIN_BITS-1:0]   cap_q, cap_d;
  logic [IN_CHAINS-1:0][CHAIN_BITS-1:0]   hist_q, hist_d;
  logic [IN_CHAINS-1:0][CHAIN_BITS-1:0]   in_data_q, in_data_d;
  logic                                   in_update_q, in_update_d;
  logic                                   busy_q, busy_d;
  logic                                   srclk_q, srclk_d;
  logic                                   rclk_q, rclk_d;
  logic                                   shld_q, shld_d;
  logic [OUT_CHAINS-1:0]                  ser_q, ser_d;
  logic                                   tick;

  // Divider phase is re-aligned at every frame start.
  serial_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clear_i ((state_q == WAIT) || (state_q == SNAP)),
    .tick_o  (tick)
  );

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    ref_d       = ref_q;
    pend_d      = pend_q;
    shadow_d    = shadow_q;
    cap_d       = cap_q;
    hist_d      = hist_q;
    in_data_d   = in_data_q;
    in_update_d = 1'b0;
    busy_d      = busy_q;
    srclk_d     = srclk_q;
    rclk_d      = rclk_q;
    shld_d      = shld_q;
    ser_d       = ser_q;

    if (frame_req && (state_q != WAIT)) pend_d = 1'b1;

    case (state_q)
      WAIT: begin
        if (frame_req || pend_q || (ref_q == REF_LAST)) begin
          state_d = SNAP;
          pend_d  = 1'b0;
          ref_d   = '0;
          busy_d  = 1'b1;
        end else begin
          ref_d = ref_q + 1'b1;
        end
      end
      SNAP: begin
        shadow_d = out_data;
        state_d  = SHOUT;
        bit_d    = BIT_MSB;
        ph_d     = PH_A;
      end
      SHOUT: if (tick) begin
        if (ph_q == PH_A) begin
          srclk_d = 1'b0;
          for (int k = 0; k < OUT_CHAINS; k++) ser_d[k] = shadow_q[k][bit_q];
          ph_d = PH_B;
        end else begin
          srclk_d = 1'b1;
          ph_d    = PH_A;
          if (bit_q == '0) state_d = LATCH;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      LATCH: if (tick) begin
        if (ph_q == PH_A) begin
          srclk_d = 1'b0;
          rclk_d  = 1'b1;
          ph_d    = PH_B;
        end else begin
          rclk_d  = 1'b0;
          ph_d    = PH_A;
          state_d = LOAD;
        end
      end
      LOAD: if (tick) begin
        if (ph_q == PH_A) begin
          shld_d = 1'b0;
          ph_d   = PH_B;
        end else begin
          shld_d  = 1'b1;
          ph_d    = PH_A;
          bit_d   = BIT_MSB;
          state_d = SHIN;
        end
      end
      // The first sample after load is the H input, so it lands in the MSB.
      SHIN: if (tick) begin
        if (ph_q == PH_A) begin
          srclk_d = 1'b0;
          for (int k = 0; k < IN_CHAINS; k++) cap_d[k][bit_q] = QH[k];
          if (bit_q == '0) state_d = COMMIT;
          else             ph_d    = PH_B;
        end else begin
          srclk_d = 1'b1;
          ph_d    = PH_A;
          bit_d   = bit_q - 1'b1;
        end
      end
      COMMIT: begin
        if ((cap_q == hist_q) && (cap_q != in_data_q)) begin
          in_data_d   = cap_q;
          in_update_d = 1'b1;
        end
        hist_d  = cap_q;
        busy_d  = 1'b0;
        ref_d   = '0;
        ph_d    = PH_A;
        state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= WAIT;
      ph_q        <= PH_A;
      bit_q       <= '0;
      ref_q       <= '0;
      pend_q      <= 1'b0;
      shadow_q    <= '0;
      cap_q       <= '0;
      hist_q      <= '0;
      in_data_q   <= '0;
      in_update_q <= 1'b0;
      busy_q      <= 1'b0;
      srclk_q     <= 1'b0;
      rclk_q      <= 1'b0;
      shld_q      <= 1'b1;
      ser_q       <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      ref_q       <= ref_d;
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
      cap_q       <= cap_d;
      hist_q      <= hist_d;
      in_data_q   <= in_data_d;
      in_update_q <= in_update_d;
      busy_q      <= busy_d;
      srclk_q     <= srclk_d;
      rclk_q      <= rclk_d;
      shld_q      <= shld_d;
      ser_q       <= ser_d;
    end
  end

  assign in_data   = in_data_q;
  assign in_update = in_update_q;
  assign busy      = busy_q;
  assign SRCLK     = srclk_q;
  assign RCLK      = rclk_q;
  assign SH_LDn    = shld_q;
  assign SER       = ser_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_panel_sequencer.sv
`default_nettype none
// ============================================================================
// tb_serial_panel_sequencer : bench with 595/165 board models and filter model
// Rev 1.0                   : initial release
// ============================================================================
module tb_serial_panel_sequencer;
  import panel_pkg::*;

  localparam int CD     = 2;
  localparam int RF     = 8;
  localparam int CB     = CHAIN_BITS;
  localparam int OC     = OUT_CHAINS;
  localparam int IC     = IN_CHAINS;
  localparam int OW     = OC * CB;
  localparam int IW     = IC * CB;
  localparam int BUDGET = 1000;
  // SNAP + (out bits*2 + latch 2 + load 2 + in bits*2-1) ticks + COMMIT
  localparam int FRAME_LEN = (2*CB + 2 + 2 + 2*CB - 1) * CD + 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [OW-1:0] out_data;
  logic          frame_req;
  logic [IW-1:0] in_data;
  logic          in_update, busy, SRCLK, RCLK, SH_LDn;
  logic [OC-1:0] SER;
  logic [IC-1:0] QH;

  always #5 clk = ~clk;

  serial_panel_sequencer #(
    .CLK_DIV (CD),
    .REFRESH (RF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .out_data  (out_data),
    .frame_req (frame_req),
    .in_data   (in_data),
    .in_update (in_update),
    .busy      (busy),
    .SRCLK     (SRCLK),
    .RCLK      (RCLK),
    .SH_LDn    (SH_LDn),
    .SER       (SER),
    .QH        (QH)
  );

  // Board models: 595 shift/storage registers and 165 load/shift registers.
  logic [IW-1:0] sw;
  logic [CB-1:0] sr595 [OC];
  logic [CB-1:0] lat595[OC];
  logic [CB-1:0] sr165 [IC];
  int            rclk_cnt = 0;

  always @(posedge SRCLK) begin
    for (int k = 0; k < OC; k++) sr595[k] <= {sr595[k][CB-2:0], SER[k]};
    if (SH_LDn) for (int k = 0; k < IC; k++) sr165[k] <= {sr165[k][CB-2:0], 1'b0};
  end

  always @(negedge SH_LDn)
    for (int k = 0; k < IC; k++) sr165[k] <= sw[k*CB +: CB];

  always @(posedge RCLK) begin
    for (int k = 0; k < OC; k++) lat595[k] <= sr595[k];
    rclk_cnt <= rclk_cnt + 1;
  end

  generate
    for (genvar k = 0; k < IC; k++) begin : g_qh
      assign QH[k] = sr165[k][CB-1];
    end
  endgenerate

  function automatic logic [OW-1:0] lamps();
    logic [OW-1:0] r;
    for (int k = 0; k < OC; k++) r[k*CB +: CB] = lat595[k];
    return r;
  endfunction

  // Busy-run length, pin-rule violations and in_update high cycles.
  int   run_len = 0, last_len = 0, viol = 0, upd_cycles = 0;
  logic prev_s = 1'b0, prev_r = 1'b0;

  always @(negedge clk) begin
    if (busy) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_len <= run_len;
      run_len  <= 0;
    end
    if ((!SH_LDn && SRCLK) || (SRCLK && !prev_s && RCLK && !prev_r)) viol <= viol + 1;
    if (in_update) upd_cycles <= upd_cycles + 1;
    prev_s <= SRCLK;
    prev_r <= RCLK;
  end

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  // Filter reference: in_data is the latest image seen in two consecutive frames.
  logic [IW-1:0] frames[$];
  logic [IW-1:0] mind = '0;
  logic          mupd = 1'b0;
  int            exp_upd_total = 0;
  int            rclk_mark = 0;

  task automatic wait_lvl(input logic lvl, output int n);
    n = 0;
    while (busy !== lvl && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== lvl) chk("busy_wait_timeout", {127'b0, busy}, {127'b0, lvl});
  endtask

  task automatic finish_frame();
    int n;
    wait_lvl(1'b0, n);
    @(negedge clk); #1;
    frames.push_back(sw);
    mupd = 1'b0;
    if (frames.size() >= 2 && frames[$] == frames[$-1] && frames[$] != mind) begin
      mind = frames[$];
      mupd = 1'b1;
      exp_upd_total++;
    end
    chk("frame_len", last_len, FRAME_LEN);
    chk("rclk_pulses", rclk_cnt - rclk_mark, 1);
    chk("model_in_update", {127'b0, in_update}, {127'b0, mupd});
    chk("model_in_data", in_data, mind);
    rclk_mark = rclk_cnt;
  endtask

  task automatic chk_reset_pins(input string name);
    chk(name, {SRCLK, RCLK, SH_LDn, SER, busy, in_update, in_data},
              {1'b0, 1'b0, 1'b1, {OC{1'b0}}, 1'b0, 1'b0, {IW{1'b0}}});
  endtask

  typedef struct {
    logic [OW-1:0] lamp;
    logic [IW-1:0] swi;
    logic [IW-1:0] exp_ind;
    logic          exp_upd;
  } vec_t;

  vec_t          tab[7];
  logic [IW-1:0] S0, S1, S2, cand[3];
  logic [OW-1:0] all_f;
  int            n, rc;

  initial begin
    S0 = {16'hBEEF, 16'h00FF, 16'hC0DE, 16'h8421, 16'h1234};
    S1 = {16'h4000, 16'h0F00, 16'h00F0, 16'h000F, 16'h0001};
    S2 = {16'h4000, 16'h0F00, 16'h00F0, 16'h000F, 16'h8001};
    tab[0] = '{{16'h0F0F, 16'h3C3C, 16'h5A5A, 16'hA5C3}, S0, '0, 1'b0};
    tab[1] = '{{16'h1111, 16'h2222, 16'h4444, 16'h8888}, S0, S0, 1'b1};
    tab[2] = '{{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001}, S1, S0, 1'b0};
    tab[3] = '{{16'h8000, 16'h7FFF, 16'hC001, 16'h3FFE}, S1, S1, 1'b1};
    tab[4] = '{{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}, S2, S1, 1'b0};
    tab[5] = '{{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, S1, S1, 1'b0};
    tab[6] = '{{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA}, S1, S1, 1'b0};
    all_f  = '1;

    resetn = 1'b0; frame_req = 1'b0; out_data = '0; sw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_pins("reset_values");

    // Table-driven frames, started by the refresh timer.
    out_data = tab[0].lamp;
    sw       = tab[0].swi;
    resetn   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        out_data = tab[i].lamp;
        sw       = tab[i].swi;
      end
      wait_lvl(1'b1, n);
      chk($sformatf("refresh_gap[%0d]", i), n, RF);
      finish_frame();
      chk($sformatf("lamps[%0d]", i), lamps(), tab[i].lamp);
      chk($sformatf("tab_in_data[%0d]", i), in_data, tab[i].exp_ind);
      chk($sformatf("tab_in_update[%0d]", i), {127'b0, in_update}, {127'b0, tab[i].exp_upd});
    end

    // Random frames started by frame_req, few distinct switch images so repeats occur.
    for (int c = 0; c < 3; c++) cand[c] = IW'({$urandom(), $urandom(), $urandom()});
    for (int r = 0; r < 12; r++) begin
      out_data = {$urandom(), $urandom()};
      sw       = cand[$urandom_range(0, 2)];
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1 frame_req = 1'b1;
      @(posedge clk); #1;
      frame_req = 1'b0;
      chk($sformatf("req_start[%0d]", r), {127'b0, busy}, 128'd1);
      finish_frame();
      chk($sformatf("rand_lamps[%0d]", r), lamps(), out_data);
    end

    // Two requests while busy collapse into one frame right after COMMIT.
    wait_lvl(1'b1, n);
    chk("pend_pre_gap", n, RF);
    repeat (10) @(posedge clk);
    #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
    repeat (10) @(posedge clk);
    #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
    finish_frame();
    wait_lvl(1'b1, n);
    chk("pend_gap", n, 1);
    finish_frame();
    wait_lvl(1'b1, n);
    chk("pend_no_third", n, RF);
    finish_frame();

    // frame_req on the last refresh count gives a single frame.
    repeat (7) @(posedge clk);
    #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
    chk("coincide_start", {127'b0, busy}, 128'd1);
    finish_frame();
    wait_lvl(1'b1, n);
    chk("coincide_gap", n, RF);
    finish_frame();

    // Lamp image changes during SHOUT: only the snapshot reaches the lamps.
    out_data = all_f;
    wait_lvl(1'b1, n);
    repeat (10) @(posedge clk);
    #1 out_data = '0;
    finish_frame();
    chk("snapshot_lamps", lamps(), all_f);
    wait_lvl(1'b1, n);
    finish_frame();
    chk("next_lamps", lamps(), '0);

    // Reset in the middle of SHIN.
    wait_lvl(1'b1, n);
    repeat (90) @(posedge clk);
    #1;
    rc     = rclk_cnt;
    resetn = 1'b0;
    #1;
    chk_reset_pins("midframe_reset");
    repeat (3) @(posedge clk);
    #1;
    chk("reset_no_rclk", rclk_cnt, rc);
    frames.delete();
    mind      = '0;
    rclk_mark = rclk_cnt;
    resetn    = 1'b1;
    wait_lvl(1'b1, n);
    chk("recover_gap", n, RF);
    finish_frame();

    chk("pin_rule_violations", viol, 0);
    chk("in_update_cycles", upd_cycles, exp_upd_total);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
